sys_arr_ctrl: RTL and testbench
===============================

SYS_ARR_CTRL -- requirements
Module: sys_arr_ctrl

Interface
REQ-001 SHALL have parameter N, default 4: systolic array dimension (N x N FP32 MAC cells); power of two, 2..16.
REQ-002 SHALL have parameter K_W, default 8: width of the input-vector count.
REQ-003 SHALL have parameter DSP_LAT, default 4: MAC pipeline latency in cycles.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  in  1  job request; k_len is sampled with it.
REQ-007 SHALL have port k_len  in  K_W  number of input vectors per job.
REQ-008 SHALL have ports w_valid in 1 / w_ready out 1: weight-row handshake.
REQ-009 SHALL have ports x_valid in 1 / x_ready out 1: input-vector handshake.
REQ-010 SHALL have ports out_valid out 1 / out_ready in 1: result-row handshake.
REQ-011 SHALL have port load_w  out  1  array weight-latch strobe.
REQ-012 SHALL have port in_shift  out  1  array advance strobe.
REQ-013 SHALL have port acc_clr  out  1  clears accumulators and dirty bits.
REQ-014 SHALL have port out_row  out  $clog2(N)  index of the result row being presented.
REQ-015 SHALL have ports arr_err in 2 / err out 2, each ordered {overflow, underflow}.
REQ-016 SHALL have ports busy out 1 (state != IDLE) and done out 1 (one-cycle completion pulse).

Function
REQ-017 SHALL implement states IDLE, LOAD, STREAM, FLUSH, DRAIN, DONE.
REQ-018 IDLE: start=1 with k_len!=0 SHALL latch k_len, pulse acc_clr for that cycle and enter LOAD on the next edge.
REQ-019 start SHALL be ignored when k_len==0 and in every state other than IDLE.
REQ-020 LOAD: w_ready=1; load_w=w_valid&w_ready (combinational); after the Nth handshake SHALL enter STREAM.
REQ-021 STREAM: x_ready=1; in_shift=x_valid; after k_len handshakes SHALL enter FLUSH.
REQ-022 FLUSH: in_shift=1 for exactly 2N-2+DSP_LAT cycles, then SHALL enter DRAIN.
REQ-023 DRAIN: out_valid=1; out_row increments on each out_valid&out_ready; after row N-1 is accepted SHALL enter DONE.
REQ-024 out_ready=0 in DRAIN SHALL hold out_valid and out_row unchanged.
REQ-025 DONE: done=1 for one cycle, then SHALL return to IDLE.
REQ-026 Handshake ready outputs SHALL be 0 outside their own state; there SHALL be no combinational path from valid to ready.
REQ-027 Counters SHALL be sized to count N and 2^K_W-1 without wrap; the count SHALL clear on every state entry.

Reset
REQ-028 rst=1 SHALL immediately force IDLE and clear all counters, the latched k_len, out_row and err.
REQ-029 During reset, all outputs SHALL be 0.
REQ-030 Reset mid-job SHALL abandon the job; no done pulse SHALL follow.

Configuration
REQ-031 Macro SYS_ARR_ERR_EN defined: err SHALL be a sticky OR of arr_err, sampled in STREAM and FLUSH only, and cleared on an accepted start.
REQ-032 Macro SYS_ARR_ERR_EN undefined: err SHALL be constant 0, arr_err SHALL be unused, and no error flops SHALL be present.

Verification
REQ-033 Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately, busy=0 after release.
REQ-034 Nominal job (N=4, DSP_LAT=4, k_len=3), start accepted at edge 0, all valid/ready held 1 -> LOAD cycles 1-4, STREAM 5-7, FLUSH 8-17, DRAIN 18-21 with out_row 0,1,2,3, done=1 at cycle 22.
REQ-035 Gapped traffic: w_valid/x_valid alternating 1/0 -> exactly 4 load_w and 3 in_shift pulses before FLUSH; job length increases by 7 cycles.
REQ-036 Backpressure: out_ready=0 for 3 cycles at out_row=1 -> out_valid stays 1, out_row stays 1, done delayed 3 cycles.
REQ-037 Ignored starts: start with k_len=0 -> state stays IDLE; start during STREAM -> no effect on k_len or counters.
REQ-038 Errors: arr_err=2'b10 for one cycle in FLUSH -> err=2'b10 until the next accepted start (macro on); err stays 2'b00 (macro off).

Source files
------------

// File: rtl/sys_arr_ctrl.sv
// rtl/sys_arr_ctrl.sv - sequencing controller for an N x N FP32 systolic MAC array
//
// Job flow: IDLE -> LOAD (N weight rows) -> STREAM (k_len input vectors)
//           -> FLUSH (2N-2+DSP_LAT pipeline drain cycles) -> DRAIN (N result rows) -> DONE.
// Optional macro SYS_ARR_ERR_EN: when defined, err is a sticky record of arr_err
// collected while data is moving through the array; when undefined, err is tied low.

module sys_arr_ctrl #(
  parameter int N       = 4,
  parameter int K_W     = 8,
  parameter int DSP_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [K_W-1:0]       k_len,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic                 x_valid,
  output logic                 x_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 load_w,
  output logic                 in_shift,
  output logic                 acc_clr,
  output logic [$clog2(N)-1:0] out_row,
  input  logic [1:0]           arr_err,
  output logic [1:0]           err,
  output logic                 busy,
  output logic                 done
);

  // Cycles needed for the last input to skew through the array and leave the MAC pipeline.
  localparam int FLUSH_LEN = 2 * N - 2 + DSP_LAT;
  localparam int CW_N      = $clog2(N + 1);
  localparam int CW_F      = $clog2(FLUSH_LEN + 1);
  localparam int CW_NF     = (CW_N > CW_F) ? CW_N : CW_F;
  // One shared phase counter, wide enough for the weight, vector and flush counts.
  localparam int CNT_W     = (K_W > CW_NF) ? K_W : CW_NF;
  localparam int ROW_W     = $clog2(N);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [K_W-1:0]   k_lat;
  logic [ROW_W-1:0] row_q;
  logic             accept;
  logic             cnt_inc;
  logic             row_last;

  // A job is accepted only from IDLE and only with a non-zero vector count.
  assign accept   = (state == IDLE) && start && (k_len != '0);
  assign row_last = (row_q == ROW_W'(N - 1));
  assign out_row  = row_q;
  assign busy     = (state != IDLE);

  // State register; reset abandons any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state decode and array strobes; ready outputs depend only on state.
  always_comb begin
    nxt       = state;
    w_ready   = 1'b0;
    x_ready   = 1'b0;
    load_w    = 1'b0;
    in_shift  = 1'b0;
    out_valid = 1'b0;
    acc_clr   = 1'b0;
    done      = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        // Gate with rst so no strobe escapes while reset is held.
        if (accept && !rst) begin
          acc_clr = 1'b1;
          nxt     = LOAD;
        end
      end
      LOAD: begin
        w_ready = 1'b1;
        load_w  = w_valid;
        cnt_inc = w_valid;
        if (w_valid && (cnt == CNT_W'(N - 1))) nxt = STREAM;
      end
      STREAM: begin
        x_ready  = 1'b1;
        in_shift = x_valid;
        cnt_inc  = x_valid;
        if (x_valid && (cnt == CNT_W'(k_lat) - CNT_W'(1))) nxt = FLUSH;
      end
      FLUSH: begin
        in_shift = 1'b1;
        cnt_inc  = 1'b1;
        if (cnt == CNT_W'(FLUSH_LEN - 1)) nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && row_last) nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Phase counter: restarts on every state change, otherwise counts accepted beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (nxt != state)  cnt <= '0;
    else if (cnt_inc)       cnt <= cnt + CNT_W'(1);
  end

  // Latch the vector count with the accepted start; later starts cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         k_lat <= '0;
    else if (accept) k_lat <= k_len;
  end

  // Result row index advances only on an accepted row, so backpressure holds it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  row_q <= '0;
    else if (state != DRAIN)                  row_q <= '0;
    else if (out_ready)                       row_q <= row_last ? '0 : row_q + ROW_W'(1);
  end

`ifdef SYS_ARR_ERR_EN
  logic [1:0] err_q;

  // Sticky error capture while operands are in the array; a new job starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        err_q <= 2'b00;
    else if (accept)                                err_q <= 2'b00;
    else if ((state == STREAM) || (state == FLUSH)) err_q <= err_q | arr_err;
  end

  assign err = err_q;
`else
  logic unused_arr_err;

  assign unused_arr_err = ^arr_err;
  assign err            = 2'b00;
`endif

endmodule

// File: tb/tb_sys_arr_ctrl.sv
// tb/tb_sys_arr_ctrl.sv - directed self-checking bench for sys_arr_ctrl (N=4, DSP_LAT=4)

module tb_sys_arr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] k_len;
  logic       w_valid, w_ready, x_valid, x_ready;
  logic       out_valid, out_ready;
  logic       load_w, in_shift, acc_clr;
  logic [1:0] out_row;
  logic [1:0] arr_err, err;
  logic       busy, done;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef SYS_ARR_ERR_EN
  localparam logic [1:0] ERR_EXP = 2'b10;
`else
  localparam logic [1:0] ERR_EXP = 2'b00;
`endif

  sys_arr_ctrl #(.N(4), .K_W(8), .DSP_LAT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .w_valid(w_valid), .w_ready(w_ready), .x_valid(x_valid), .x_ready(x_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .load_w(load_w), .in_shift(in_shift), .acc_clr(acc_clr), .out_row(out_row),
    .arr_err(arr_err), .err(err), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [7:0]  k_len;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[25];

  // {busy, w_ready, x_ready, load_w, in_shift, acc_clr, out_valid, done, out_row, err}
  function automatic logic [11:0] outs();
    return {busy, w_ready, x_ready, load_w, in_shift, acc_clr, out_valid, done, out_row, err};
  endfunction

  function automatic logic [11:0] mk(input bit b, input bit wr, input bit xr, input bit lw,
                                     input bit sh, input bit ac, input bit ov, input bit dn,
                                     input logic [1:0] row);
    return {b, wr, xr, lw, sh, ac, ov, dn, row, 2'b00};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Run one k_len=3 job from an IDLE controller. Cycle 0 carries start.
  // gap: valids low on odd cycles; bp: out_ready low for cycles bp..bp+2; ec: arr_err=10 at cycle ec.
  task automatic run_job(input bit gap, input int bp, input int ec,
                         output int done_cyc, output int nload, output int nshift);
    done_cyc = -1; nload = 0; nshift = 0;
    for (int c = 0; c < 100; c++) begin
      start     = (c == 0);
      k_len     = 8'd3;
      w_valid   = gap ? (c % 2 == 0) : 1'b1;
      x_valid   = w_valid;
      out_ready = !(bp > 0 && c >= bp && c <= bp + 2);
      arr_err   = (c == ec) ? 2'b10 : 2'b00;
      @(negedge clk);
      nload += int'(load_w);
      if (x_ready && in_shift) nshift++;
      if (bp > 0 && c >= bp && c <= bp + 2)
        chk($sformatf("bp_hold_c%0d", c), {out_valid, out_row}, {1'b1, 2'd1});
      @(posedge clk); #1;
      if (done_cyc < 0 && c > 0 && dut.state == dut.DONE) done_cyc = c + 1;
      if (done_cyc >= 0 && c + 1 >= done_cyc + 1) break;
    end
    start = 0; w_valid = 0; x_valid = 0; out_ready = 1; arr_err = 0;
  endtask

  initial begin
    int dc, nl, ns, ndone, nbusy;

    // Hand-derived nominal timeline (start accepted at edge 0): LOAD 1-4, STREAM 5-7,
    // FLUSH 8-17, DRAIN 18-21 (rows 0..3), DONE 22. Extra starts at 6 (STREAM) and 23/24 (k_len=0).
    for (int c = 0; c < 25; c++) begin
      vecs[c].start = (c == 0) || (c == 6) || (c >= 23);
      vecs[c].k_len = (c == 0) ? 8'd3 : (c == 6) ? 8'd7 : 8'd0;
      vecs[c].exp   = mk(c >= 1 && c <= 22, c >= 1 && c <= 4, c >= 5 && c <= 7,
                         c >= 1 && c <= 4, c >= 5 && c <= 17, c == 0,
                         c >= 18 && c <= 21, c == 22,
                         (c >= 18 && c <= 21) ? 2'(c - 18) : 2'd0);
    end

    rst = 1; start = 1; k_len = 8'd3; w_valid = 1; x_valid = 1; out_ready = 1; arr_err = 2'b11;
    #3;
    chk("reset_outputs", 32'(outs()), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("reset_held_outputs", 32'(outs()), 32'd0);
    start = 0; arr_err = 0;
    rst = 0;
    @(negedge clk);
    chk("post_reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Nominal job from the vector table.
    for (int c = 0; c < 25; c++) begin
      start = vecs[c].start; k_len = vecs[c].k_len;
      w_valid = 1; x_valid = 1; out_ready = 1; arr_err = 0;
      @(negedge clk);
      chk($sformatf("nominal_c%0d", c), 32'(outs()), 32'(vecs[c].exp));
      @(posedge clk); #1;
    end
    start = 0; w_valid = 0; x_valid = 0;
    chk("k_len_zero_idle", 32'(busy), 32'd0);

    // Gapped traffic: valid alternates starting low -> +7 cycles.
    run_job(1'b1, 0, -1, dc, nl, ns);
    chk("gap_load_w_count", 32'(nl), 32'd4);
    chk("gap_in_shift_count", 32'(ns), 32'd3);
    chk("gap_done_cycle", 32'(dc), 32'd29);

    // Backpressure at out_row=1 for 3 cycles -> done 3 cycles later.
    run_job(1'b0, 19, -1, dc, nl, ns);
    chk("bp_done_cycle", 32'(dc), 32'd25);

    // Error during FLUSH.
    run_job(1'b0, 0, 10, dc, nl, ns);
    chk("err_done_cycle", 32'(dc), 32'd22);
    chk("err_after_job", 32'(err), 32'(ERR_EXP));
    start = 1; k_len = 0; arr_err = 2'b01;
    @(posedge clk); #1;
    start = 0; arr_err = 0;
    chk("err_kept_on_rejected_start", 32'(err), 32'(ERR_EXP));
    start = 1; k_len = 8'd3;
    @(posedge clk); #1;
    start = 0;
    chk("err_cleared_on_start", 32'(err), 32'd0);
    for (int i = 0; i < 30 && busy; i++) begin
      w_valid = 1; x_valid = 1; out_ready = 1;
      @(posedge clk); #1;
    end
    w_valid = 0; x_valid = 0;
    chk("err_second_job_idle", 32'(busy), 32'd0);

    // Asynchronous reset mid-STREAM abandons the job.
    start = 1; k_len = 8'd3; w_valid = 1; x_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    chk("midjob_in_stream", 32'(x_ready), 32'd1);
    #2 rst = 1;
    #1;
    chk("midjob_reset_outputs", 32'(outs()), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    ndone = 0; nbusy = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      ndone += int'(done);
      nbusy += int'(busy);
    end
    chk("midjob_no_done", 32'(ndone), 32'd0);
    chk("midjob_busy_after_release", 32'(nbusy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
